// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter sharing one registered elastic output slot among
// NEIGHBOR_PE_NUM valid/stop producers; 1 word/cycle, 1-cycle latency.
module elastic_rr_arbiter #(
  parameter int unsigned DATA_WIDTH                 = 32,
  parameter int unsigned NEIGHBOR_PE_NUM            = 4,
  parameter int unsigned NEIGHBOR_PE_NUM_BIT_LENGTH = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 data_input [NEIGHBOR_PE_NUM],
  input  logic [NEIGHBOR_PE_NUM-1:0]            valid_input,
  output logic [NEIGHBOR_PE_NUM-1:0]            stop_input,
  input  logic [NEIGHBOR_PE_NUM-1:0]            input_enable,
  output logic [DATA_WIDTH-1:0]                 data_output,
  output logic                                  valid_output,
  input  logic                                  stop_output,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] grant_index
);

  localparam logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] LAST_INDEX =
    NEIGHBOR_PE_NUM_BIT_LENGTH'(NEIGHBOR_PE_NUM - 1);

  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] ptr;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] sel;
  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] idx;
  logic [NEIGHBOR_PE_NUM-1:0]            eligible;
  logic                                  any_eligible;
  logic                                  can_load;
  logic                                  load;

  assign eligible = valid_input & input_enable;
  assign can_load = !valid_output || !stop_output;
  assign load     = can_load && any_eligible;

  // Search ptr+1 .. ptr with explicit modulo-N wrap, so non-power-of-2 N works.
  always_comb begin
    sel          = ptr;
    any_eligible = 1'b0;
    idx          = ptr;
    for (int unsigned k = 0; k < NEIGHBOR_PE_NUM; k++) begin
      idx = (idx == LAST_INDEX) ? '0 : idx + 1'b1;
      if (eligible[idx] && !any_eligible) begin
        sel          = idx;
        any_eligible = 1'b1;
      end
    end
  end

  always_comb begin
    stop_input = '1;
    if (load) stop_input[sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_output  <= '0;
      valid_output <= 1'b0;
      grant_index  <= '0;
      ptr          <= LAST_INDEX;
    end else if (load) begin
      data_output  <= data_input[sel];
      valid_output <= 1'b1;
      grant_index  <= sel;
      ptr          <= sel;
    end else if (!stop_output) begin
      valid_output <= 1'b0;
    end
  end

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Directed self-checking bench for elastic_rr_arbiter (N=4, 32-bit data).
module tb_elastic_rr_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_input [N];
  logic [N-1:0] valid_input;
  logic [N-1:0] stop_input;
  logic [N-1:0] input_enable;
  logic [31:0] data_output;
  logic        valid_output;
  logic        stop_output;
  logic [1:0]  grant_index;

  int checks = 0;
  int errors = 0;

  elastic_rr_arbiter #(
    .DATA_WIDTH(32),
    .NEIGHBOR_PE_NUM(4),
    .NEIGHBOR_PE_NUM_BIT_LENGTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_input(data_input),
    .valid_input(valid_input),
    .stop_input(stop_input),
    .input_enable(input_enable),
    .data_output(data_output),
    .valid_output(valid_output),
    .stop_output(stop_output),
    .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_all_data(input logic [31:0] base);
    for (int i = 0; i < N; i++) data_input[i] = base + 32'(i);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    valid_input  = '0;
    input_enable = '1;
    stop_output  = 1'b0;
    set_all_data(32'h0);
    #1;
    checks++;
    if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_output); end
    checks++;
    if (data_output !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_output); end
    checks++;
    if (grant_index !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_index); end
    checks++;
    if (stop_input !== 4'b1111) begin errors++; $display("FAIL reset_stop got %b exp 1111", stop_input); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_requester();
    logic [31:0] exp_d;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_d          = 32'hA0 + 32'(k);
      valid_input    = 4'b0100;
      data_input[2]  = exp_d;
      #1;
      checks++;
      if (stop_input !== 4'b1011) begin errors++; $display("FAIL single_stop[%0d] got %b exp 1011", k, stop_input); end
      @(posedge clk); #1;
      checks++;
      if (valid_output !== 1'b1 || data_output !== exp_d || grant_index !== 2'd2) begin
        errors++;
        $display("FAIL single_out[%0d] got v=%b d=%h g=%0d exp v=1 d=%h g=2",
                 k, valid_output, data_output, grant_index, exp_d);
      end
    end
    @(negedge clk);
    valid_input = '0;
    #1;
    checks++;
    if (stop_input !== 4'b1111) begin errors++; $display("FAIL idle_stop got %b exp 1111", stop_input); end
    @(posedge clk); #1;
    checks++;
    if (valid_output !== 1'b0 || data_output !== 32'hA2 || grant_index !== 2'd2) begin
      errors++;
      $display("FAIL drain_idle got v=%b d=%h g=%0d exp v=0 d=a2 g=2", valid_output, data_output, grant_index);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    pulse_reset();
    set_all_data(32'h10);
    input_enable = 4'b1111;
    valid_input  = 4'b1111;
    stop_output  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (stop_input !== ~(4'b0001 << exp_g[k])) begin
        errors++; $display("FAIL rr_stop[%0d] got %b exp %b", k, stop_input, ~(4'b0001 << exp_g[k]));
      end
      @(posedge clk); #1;
      checks++;
      if (valid_output !== 1'b1 || grant_index !== exp_g[k] || data_output !== 32'h10 + 32'(exp_g[k])) begin
        errors++;
        $display("FAIL rr_out[%0d] got v=%b g=%0d d=%h exp v=1 g=%0d d=%h",
                 k, valid_output, grant_index, data_output, exp_g[k], 32'h10 + 32'(exp_g[k]));
      end
      @(negedge clk);
    end
  endtask

  // Continues from test_round_robin: slot holds word 0x10 from requester 0.
  task automatic test_stall();
    stop_output = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (stop_input !== 4'b1111) begin errors++; $display("FAIL stall_stop[%0d] got %b exp 1111", k, stop_input); end
      @(posedge clk); #1;
      checks++;
      if (valid_output !== 1'b1 || data_output !== 32'h10 || grant_index !== 2'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h g=%0d exp v=1 d=10 g=0", k, valid_output, data_output, grant_index);
      end
      @(negedge clk);
    end
    stop_output = 1'b0;
    #1;
    checks++;
    if (stop_input !== 4'b1101) begin errors++; $display("FAIL unstall_stop got %b exp 1101", stop_input); end
    @(posedge clk); #1;
    checks++;
    if (valid_output !== 1'b1 || data_output !== 32'h11 || grant_index !== 2'd1) begin
      errors++;
      $display("FAIL unstall_load got v=%b d=%h g=%0d exp v=1 d=11 g=1", valid_output, data_output, grant_index);
    end
  endtask

  task automatic test_enable_mask();
    logic [1:0] exp_g [4];
    exp_g = '{2'd0, 2'd2, 2'd3, 2'd0};
    pulse_reset();
    set_all_data(32'h50);
    valid_input  = 4'b1111;
    input_enable = 4'b1101;
    stop_output  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (stop_input[1] !== 1'b1 || stop_input !== ~(4'b0001 << exp_g[k])) begin
        errors++; $display("FAIL mask_stop[%0d] got %b exp %b", k, stop_input, ~(4'b0001 << exp_g[k]));
      end
      @(posedge clk); #1;
      checks++;
      if (grant_index !== exp_g[k] || data_output !== 32'h50 + 32'(exp_g[k])) begin
        errors++;
        $display("FAIL mask_out[%0d] got g=%0d d=%h exp g=%0d d=%h",
                 k, grant_index, data_output, exp_g[k], 32'h50 + 32'(exp_g[k]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_stall();
    input_enable = 4'b1111;
    stop_output  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_output !== 1'b1) begin errors++; $display("FAIL prestall_valid got %b exp 1", valid_output); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (valid_output !== 1'b0 || data_output !== 32'h0 || grant_index !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h g=%0d exp v=0 d=0 g=0", valid_output, data_output, grant_index);
    end
    @(negedge clk);
    reset       = 1'b0;
    stop_output = 1'b0;
    set_all_data(32'h70);
    @(posedge clk); #1;
    checks++;
    if (valid_output !== 1'b1 || grant_index !== 2'd0 || data_output !== 32'h70) begin
      errors++;
      $display("FAIL post_reset_grant got v=%b g=%0d d=%h exp v=1 g=0 d=70", valid_output, grant_index, data_output);
    end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_stall();
    test_enable_mask();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
